// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul output path.
//   - Default array geometry (element width, chunk size, core grid, run length).
//   - Derived widths: OUT_W (one stream beat), IN_W (one wide result word).
//   - Collector FSM state encoding (COLLECT=0, FETCH=1, LOAD=2, DRAIN=3).
//   - clog2_min1: clog2 that never returns 0, for counters and addresses
//     that must stay at least one bit wide.
package matmul_pkg;

  localparam int WIDTH_OUT   = 16;
  localparam int CHUNK_SIZE  = 4;
  localparam int NUM_CORES_A = 4;
  localparam int NUM_CORES_B = 4;
  localparam int NUM_RESULTS = 4;

  localparam int SLICES = NUM_CORES_A * NUM_CORES_B;
  localparam int OUT_W  = WIDTH_OUT * CHUNK_SIZE;
  localparam int IN_W   = OUT_W * SLICES;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/matmul_out_buffer.sv
// Simple dual-port result buffer, written in the style that maps onto block RAM.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read address
//   rdata_o  out  read data, valid one cycle after re_i
// The array and the read register carry no reset so the tools can pack them
// into a RAM primitive.
module matmul_out_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1024,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/matmul_out_collector.sv
// Collects a run of wide matmul result words, then streams each word out as
// SLICES beats of OUT_W bits, least-significant slice first.
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   in_valid     in   one-cycle pulse: in_data holds a result word
//   in_data      in   IN_W-bit result word
//   m_valid      out  stream beat valid
//   m_ready      in   downstream accepts beat
//   m_data       out  OUT_W-bit beat payload
//   m_last       out  final beat of the run
//   busy         out  run in progress (not idle in COLLECT with empty buffer)
//   overflow     out  sticky: a word arrived while the collector was draining
//   dbg_state_o  out  current FSM state
// Stream handshake: a beat transfers on a rising edge where m_valid && m_ready;
// once m_valid is high, m_data and m_last hold until that transfer, and
// m_ready is ignored while m_valid is low.
module matmul_out_collector
  import matmul_pkg::*;
#(
  parameter int WIDTH_OUT   = matmul_pkg::WIDTH_OUT,
  parameter int CHUNK_SIZE  = matmul_pkg::CHUNK_SIZE,
  parameter int NUM_CORES_A = matmul_pkg::NUM_CORES_A,
  parameter int NUM_CORES_B = matmul_pkg::NUM_CORES_B,
  parameter int NUM_RESULTS = matmul_pkg::NUM_RESULTS,
  localparam int SLICES = NUM_CORES_A * NUM_CORES_B,
  localparam int OUT_W  = WIDTH_OUT * CHUNK_SIZE,
  localparam int IN_W   = OUT_W * SLICES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  localparam int PTR_W = $clog2(NUM_RESULTS + 1);
  localparam int SL_W  = clog2_min1(SLICES);
  localparam int AW    = clog2_min1(NUM_RESULTS);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_RESULTS - 1);
  localparam logic [SL_W-1:0]  SL_LAST  = SL_W'(SLICES - 1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SL_W-1:0]  sl_q, sl_d;
  logic [IN_W-1:0]  hold_q, hold_d;
  logic             m_valid_q, m_valid_d;
  logic             overflow_q, overflow_d;

  logic             buf_we;
  logic             buf_re;
  logic [IN_W-1:0]  buf_rdata;

  matmul_out_buffer #(
    .DEPTH (NUM_RESULTS),
    .WIDTH (IN_W),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_data),
    .re_i    (buf_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sl_d       = sl_q;
    hold_d     = hold_q;
    m_valid_d  = m_valid_q;
    overflow_d = overflow_q;
    buf_we     = 1'b0;
    buf_re     = 1'b0;

    // Words arriving outside COLLECT are lost; flag it and leave the buffer alone.
    if (in_valid && (state_q != ST_COLLECT)) overflow_d = 1'b1;

    case (state_q)
      ST_COLLECT: begin
        if (in_valid) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == PTR_LAST) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        buf_re  = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        hold_d    = buf_rdata;
        sl_d      = '0;
        m_valid_d = 1'b1;
        state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (m_valid_q && m_ready) begin
          if (sl_q != SL_LAST) begin
            sl_d = sl_q + SL_W'(1);
          end else begin
            m_valid_d = 1'b0;
            sl_d      = '0;
            if (rd_ptr_q != PTR_LAST) begin
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
              state_d  = ST_FETCH;
            end else begin
              rd_ptr_d = '0;
              wr_ptr_d = '0;
              state_d  = ST_COLLECT;
            end
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sl_q       <= '0;
      hold_q     <= '0;
      m_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sl_q       <= sl_d;
      hold_q     <= hold_d;
      m_valid_q  <= m_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload is a mux of the held word, so it can only change when sl_q or
  // hold_q change, which happens on an accepted beat or in LOAD.
  assign m_data      = hold_q[int'(sl_q)*OUT_W +: OUT_W];
  assign m_valid     = m_valid_q;
  assign m_last      = m_valid_q && (rd_ptr_q == PTR_LAST) && (sl_q == SL_LAST);
  assign busy        = (state_q != ST_COLLECT) || (wr_ptr_q != '0);
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matmul_out_collector.sv
module tb_matmul_out_collector;

  localparam int NR    = 4;
  localparam int SL    = 16;
  localparam int OW    = 64;
  localparam int IW    = OW * SL;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default build
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          m_valid, m_ready, m_last, busy, overflow;
  logic [OW-1:0] m_data;
  logic [1:0]    dbg_state;

  // single-word, 4-slice build
  logic          in_valid_b;
  logic [63:0]   in_data_b;
  logic          m_valid_b, m_ready_b, m_last_b, busy_b, overflow_b;
  logic [15:0]   m_data_b;
  logic [1:0]    dbg_state_b;

  matmul_out_collector dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .overflow(overflow), .dbg_state_o(dbg_state)
  );

  matmul_out_collector #(
    .WIDTH_OUT(16), .CHUNK_SIZE(1), .NUM_CORES_A(2), .NUM_CORES_B(2), .NUM_RESULTS(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b),
    .busy(busy_b), .overflow(overflow_b), .dbg_state_o(dbg_state_b)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] mk_slice(input int run, input int n, input int k);
    return {16'(run), 16'(n), 16'(k), 16'h5a5a};
  endfunction

  function automatic logic [IW-1:0] mk_word(input int run, input int n);
    logic [IW-1:0] w;
    for (int k = 0; k < SL; k++) w[k*OW +: OW] = mk_slice(run, n, k);
    return w;
  endfunction

  // driver: one word per cycle starting at the current negedge; expected
  // beats are queued as the words are driven
  task automatic load_run(input int run);
    for (int n = 0; n < NR; n++) begin
      in_valid = 1'b1;
      in_data  = mk_word(run, n);
      for (int k = 0; k < SL; k++) begin
        exp_q.push_back(mk_slice(run, n, k));
        exp_last_q.push_back((n == NR - 1) && (k == SL - 1));
      end
      @(negedge clk);
      if (n == 0) chk("busy_collecting", 64'(busy), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  // consumer: compares accepted beats against the queue; optional random
  // backpressure, a stray in_valid pulse at beat ovf_at, reset at beat rst_at
  task automatic drain(input bit rnd, input int ovf_at, input int rst_at, input bit chk_lat);
    int cyc = 0;
    int first = -1;
    int beats = 0;
    bit ovf_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [OW-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    logic [OW-1:0] e;
    logic el;
    while (exp_q.size() > 0 && cyc < 4000) begin
      if (m_valid && first < 0) first = cyc;
      if (prev_stall) begin
        chk("stall_data_stable", m_data, prev_d);
        chk("stall_last_stable", 64'(m_last), 64'(prev_l));
      end
      if (rst_at >= 0 && beats == rst_at) begin
        chk("overflow_sticky", 64'(overflow), 64'd1);
        rst_n = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0 | 1'b1;
        chk("rst_mid_m_valid", 64'(m_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_overflow", 64'(overflow), 64'd0);
        chk("rst_mid_m_last", 64'(m_last), 64'd0);
        chk("rst_mid_m_data", m_data, 64'd0);
        chk("rst_mid_state", 64'(dbg_state), 64'd0);
        exp_q.delete();
        exp_last_q.delete();
        return;
      end
      if (ovf_at >= 0 && beats == ovf_at && !ovf_done) begin
        in_valid = 1'b1;
        in_data  = {16{64'hdead_beef_dead_beef}};
        ovf_done = 1'b1;
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        e  = exp_q.pop_front();
        el = exp_last_q.pop_front();
        chk("beat_data", m_data, e);
        chk("beat_last", 64'(m_last), 64'(el));
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout_beats_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_last_q.delete();
    end
    if (chk_lat) chk("first_beat_latency", 64'(first), 64'd2);
    chk("m_valid_after_run", 64'(m_valid), 64'd0);
    chk("busy_after_run", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; m_ready = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; m_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_last", 64'(m_last), 64'd0);
    chk("reset_m_data", m_data, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: full-rate drain
    load_run(1);
    drain(1'b0, -1, -1, 1'b1);
    chk("t1_overflow_clear", 64'(overflow), 64'd0);

    // T2: random backpressure
    @(negedge clk);
    load_run(2);
    drain(1'b1, -1, -1, 1'b1);

    // T3: stray word during drain
    @(negedge clk);
    load_run(3);
    drain(1'b1, 10, -1, 1'b0);
    chk("t3_overflow_set", 64'(overflow), 64'd1);

    // T4: reset at beat 20, then a clean run
    @(negedge clk);
    load_run(4);
    drain(1'b0, -1, 20, 1'b0);
    @(negedge clk);
    load_run(5);
    drain(1'b1, -1, -1, 1'b1);

    // T5: back-to-back runs, second starts right after the final accept
    load_run(6);
    drain(1'b0, -1, -1, 1'b1);
    load_run(7);
    drain(1'b1, -1, -1, 1'b1);
    chk("t5_no_overflow", 64'(overflow), 64'd0);

    // T6: one-word build, 4 beats of 16 bits
    in_valid_b = 1'b1;
    in_data_b  = 64'h0004_0003_0002_0001;
    @(negedge clk);
    in_valid_b = 1'b0;
    m_ready_b  = 1'b1;
    chk("t6_busy", 64'(busy_b), 64'd1);
    chk("t6_valid_t1", 64'(m_valid_b), 64'd0);
    @(negedge clk);
    chk("t6_valid_t2", 64'(m_valid_b), 64'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("t6_beat_valid", 64'(m_valid_b), 64'd1);
      chk("t6_beat_data", 64'(m_data_b), 64'(k + 1));
      chk("t6_beat_last", 64'(m_last_b), 64'(k == 3));
      @(negedge clk);
    end
    chk("t6_valid_after", 64'(m_valid_b), 64'd0);
    chk("t6_busy_after", 64'(busy_b), 64'd0);
    chk("t6_overflow", 64'(overflow_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
